// File: rtl/inv_sqrt_pkg.sv
// Shared types and constants for the fixed-point inverse square root engine.
package inv_sqrt_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TO_FLOAT = 3'd1,
    S_HACK     = 3'd2,
    S_TO_FIX   = 3'd3,
    S_NR       = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h5f3759df;

  // 1.5 in a Q(x.fract_width) format; fract_width 0 cannot represent the half.
  function automatic logic [63:0] three_halves(input int fract_width);
    return (fract_width == 0) ? 64'd1 : (64'd3 << (fract_width - 1));
  endfunction

endpackage

// File: rtl/inv_sqrt_nr_step.sv
// One Newton-Raphson refinement of y ~ 1/sqrt(x): y' = y * (1.5 - (x/2) * y * y).
module inv_sqrt_nr_step
  import inv_sqrt_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] i_x_half,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] i_y,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] o_y_next
);

  localparam int W  = INT_WIDTH + FRACT_WIDTH;
  localparam int W2 = 2 * W;
  localparam int W3 = 3 * W;
  localparam int PW = 2 * W + 2;
  localparam logic [PW-1:0] THREE_HALVES_Q = PW'(three_halves(FRACT_WIDTH));

  logic [W2-1:0] w_sq;
  logic [W2-1:0] w_yy;
  logic [W3-1:0] w_xyy;
  logic [W3-1:0] w_xyy_q;
  logic [PW-1:0] w_t;
  logic [PW-1:0] w_bracket;
  logic [PW-1:0] w_prod;

  assign w_sq    = W2'(i_y) * W2'(i_y);
  assign w_yy    = w_sq >> FRACT_WIDTH;
  assign w_xyy   = W3'(i_x_half) * W3'(w_yy);
  assign w_xyy_q = w_xyy >> FRACT_WIDTH;

  // An oversized (x/2)*y*y only has to exceed 1.5, so pinning it at all-ones is exact enough.
  assign w_t       = ((w_xyy_q >> PW) != '0) ? '1 : w_xyy_q[PW-1:0];
  assign w_bracket = (w_t >= THREE_HALVES_Q) ? '0 : (THREE_HALVES_Q - w_t);
  assign w_prod    = (PW'(i_y) * w_bracket) >> FRACT_WIDTH;
  assign o_y_next  = ((w_prod >> W) != '0) ? '1 : w_prod[W-1:0];

endmodule

// File: rtl/inv_sqrt_engine.sv
// Fixed-point 1/sqrt(x): float bit-hack seed followed by NR_ITERS Newton steps, valid/ready on both sides.
module inv_sqrt_engine
  import inv_sqrt_pkg::*;
#(
  parameter int          INT_WIDTH   = 12,
  parameter int          FRACT_WIDTH = 4,
  parameter int          NR_ITERS    = 1,
  parameter logic [31:0] MAGIC       = DEFAULT_MAGIC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic                             zero_err,
  output logic                             busy
);

  localparam int         W         = INT_WIDTH + FRACT_WIDTH;
  localparam logic [1:0] ITER_LAST = 2'(NR_ITERS - 1);

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic [31:0]    r_float;
  logic [31:0]    r_y0_bits;
  logic [W-1:0]   r_y;
  logic [1:0]     r_iter;
  logic [W-1:0]   r_data_out;
  logic           r_valid_out;
  logic           r_zero_err;

  logic [W-1:0]   w_x_half;
  logic [W-1:0]   w_y0_fix;
  logic [W-1:0]   w_y_next;

  // Nonzero operand to IEEE-754 single; mantissa is truncated, never rounded.
  function automatic logic [31:0] to_float(input logic [W-1:0] x);
    int          m;
    logic [31:0] xs;
    logic [7:0]  e;
    // NOTE: every function local gets a value before any conditional use, so no path leaves it stale.
    m = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) m = i;
    end
    xs = 32'(x) << (31 - m);
    e  = 8'(m - FRACT_WIDTH + 127);
    return {1'b0, e, 23'(xs >> 8)};
  endfunction

  // IEEE-754 single to Q(INT_WIDTH.FRACT_WIDTH), truncating and saturating.
  function automatic logic [W-1:0] to_fix(input logic [31:0] f);
    logic [23:0]  sig;
    logic [63:0]  wide;
    logic [W-1:0] res;
    int           sh;
    sig  = {1'b1, f[22:0]};
    sh   = int'(f[30:23]) - 150 + FRACT_WIDTH;
    wide = '0;
    if (f[31] || (f[30:23] == 8'd0)) begin
      res = '0;
    end else if (sh > 40) begin
      res = '1;
    end else begin
      if (sh >= 0)       wide = 64'(sig) << sh;
      else if (sh > -24) wide = 64'(sig) >> (-sh);
      res = ((wide >> W) != 64'd0) ? '1 : wide[W-1:0];
    end
    return res;
  endfunction

  assign w_x_half = r_x >> 1;
  assign w_y0_fix = to_fix(r_y0_bits);

  inv_sqrt_nr_step #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_nr_step (
    .i_x_half (w_x_half),
    .i_y      (r_y),
    .o_y_next (w_y_next)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_float     <= '0;
      r_y0_bits   <= '0;
      r_y         <= '0;
      r_iter      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_zero_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_x     <= data_in;
            r_state <= S_TO_FLOAT;
          end
        end
        S_TO_FLOAT: begin
          if (r_x == '0) begin
            r_data_out  <= '1;
            r_zero_err  <= 1'b1;
            r_valid_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_float <= to_float(r_x);
            r_state <= S_HACK;
          end
        end
        S_HACK: begin
          r_y0_bits <= MAGIC - (r_float >> 1);
          r_state   <= S_TO_FIX;
        end
        S_TO_FIX: begin
          r_y    <= w_y0_fix;
          r_iter <= '0;
          if (NR_ITERS == 0) begin
            r_data_out  <= w_y0_fix;
            r_zero_err  <= 1'b0;
            r_valid_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_NR;
          end
        end
        S_NR: begin
          r_y <= w_y_next;
          if (r_iter == ITER_LAST) begin
            r_data_out  <= w_y_next;
            r_zero_err  <= 1'b0;
            r_valid_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_iter <= r_iter + 2'd1;
          end
        end
        S_DONE: begin
          if (ready_out) begin
            r_valid_out <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_in  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_inv_sqrt_engine.sv
// Directed bench for inv_sqrt_engine (Q12.4) with NR_ITERS = 1, 0 and 3 instances.
module tb_inv_sqrt_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        ready_out;
  logic        v0, v1, v3;
  logic        ri0, ri1, ri3;
  logic [15:0] do0, do1, do3;
  logic        vo0, vo1, vo3;
  logic        ze0, ze1, ze3;
  logic        bz0, bz1, bz3;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sqrt_engine #(.NR_ITERS(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(v1), .ready_in(ri1),
    .data_out(do1), .valid_out(vo1), .ready_out(ready_out), .zero_err(ze1), .busy(bz1)
  );
  inv_sqrt_engine #(.NR_ITERS(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(v0), .ready_in(ri0),
    .data_out(do0), .valid_out(vo0), .ready_out(ready_out), .zero_err(ze0), .busy(bz0)
  );
  inv_sqrt_engine #(.NR_ITERS(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(v3), .ready_in(ri3),
    .data_out(do3), .valid_out(vo3), .ready_out(ready_out), .zero_err(ze3), .busy(bz3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer x to dut1; returns the cycle stamp of the accepting edge, or -1.
  task automatic send1(input logic [15:0] x, output int acc_cyc);
    data_in = x;
    v1      = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (ri1) begin
        tick();
        acc_cyc = cyc;
        break;
      end
      tick();
    end
    v1 = 1'b0;
  endtask

  task automatic wait_v1(output int lat);
    lat = 0;
    while (!vo1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run1(input string tag, input logic [15:0] x, input logic [15:0] exp_d,
                      input int exp_lat, input logic exp_ze, output logic [15:0] got);
    int acc, lat;
    send1(x, acc);
    check({tag, "_accepted"}, acc >= 0, 1'b1);
    wait_v1(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, do1, exp_d);
    check({tag, "_zero_err"}, ze1, exp_ze);
    got = do1;
    tick();
    check({tag, "_drained"}, {vo1, ri1}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d1, dtmp, d0, d3;
    int          a1, a2, lat, lat0, lat3, seen, e0, e1, e3;

    rst = 1'b1; data_in = '0; ready_out = 1'b1; v0 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid_out", vo1, 1'b0);
    check("rst_data_out", do1, 16'h0000);
    check("rst_zero_err", ze1, 1'b0);
    check("rst_busy", bz1, 1'b0);
    check("rst_ready_in", ri1, 1'b1);

    // 4.0: seed 0x3EF759DF -> 7.73/16 -> 7; NR: yy=3, t=6, bracket=18, 7*18>>4 = 7.
    run1("x4", 16'h0040, 16'h0007, 4, 1'b0, d1);

    // Back-to-back 16.0 then 1.0: seeds 3 and 15; NR gives 4 and 15.
    send1(16'h0100, a1);
    wait_v1(lat);
    check("b2b_first_latency", lat, 4);
    check("b2b_first_data", do1, 16'h0004);
    send1(16'h0010, a2);
    check("b2b_accept_spacing", a2 - a1, 6);
    wait_v1(lat);
    check("b2b_second_latency", lat, 4);
    check("b2b_second_data", do1, 16'h000F);
    tick();

    run1("zero", 16'h0000, 16'hFFFF, 1, 1'b1, dtmp);
    // 1/16: seed 0x407759DF -> 61; x/2 truncates to 0, so bracket=1.5 -> 91.
    run1("x_lsb", 16'h0001, 16'h005B, 4, 1'b0, dtmp);
    // Max operand: seed 0.24 LSB truncates to 0 and stays 0.
    run1("x_max", 16'hFFFF, 16'h0000, 4, 1'b0, dtmp);

    // Backpressure: hold ready_out low for 10 cycles in DONE.
    ready_out = 1'b0;
    send1(16'h0100, a1);
    wait_v1(lat);
    check("hold_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_c%0d", i), {vo1, ri1, do1}, {1'b1, 1'b0, 16'h0004});
      tick();
    end
    ready_out = 1'b1;
    tick();
    check("hold_consumed", {vo1, ri1}, 2'b01);

    // Reset while in NR.
    send1(16'h0040, a1);
    tick();
    tick();
    tick();
    check("pre_rst_busy", bz1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", {vo1, ri1, bz1, ze1, do1}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (vo1) seen++;
      tick();
    end
    check("mid_rst_no_stale", seen, 0);

    // NR_ITERS = 0 and 3 on the same operand, launched on the same edge.
    data_in = 16'h0040;
    v0 = 1'b1;
    v3 = 1'b1;
    tick();
    v0 = 1'b0;
    v3 = 1'b0;
    lat0 = -1;
    lat3 = -1;
    d0 = '0;
    d3 = '0;
    for (int k = 0; k < 15; k++) begin
      if (vo0 && lat0 < 0) begin lat0 = k; d0 = do0; end
      if (vo3 && lat3 < 0) begin lat3 = k; d3 = do3; end
      tick();
    end
    check("nr0_latency", lat0, 3);
    check("nr3_latency", lat3, 6);
    check("nr0_data", d0, 16'h0007);
    check("nr3_data", d3, 16'h0007);
    e0 = (d0 > 16'd8) ? int'(d0) - 8 : 8 - int'(d0);
    e1 = (d1 > 16'd8) ? int'(d1) - 8 : 8 - int'(d1);
    e3 = (d3 > 16'd8) ? int'(d3) - 8 : 8 - int'(d3);
    check("err_non_increasing", (e3 <= e1) && (e1 <= e0), 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_sqrt_engine.md
INV_SQRT_ENGINE -- requirements
Module: inv_sqrt_engine

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 12, integer bits of unsigned fixed-point operand/result.
REQ-002 SHALL have parameter FRACT_WIDTH, default 4, fractional bits; W = INT_WIDTH+FRACT_WIDTH, legal W 8..32.
REQ-003 SHALL have parameter NR_ITERS, default 1, Newton-Raphson refinement iterations, legal 0..3.
REQ-004 SHALL have parameter MAGIC, default 32'h5f3759df, bit-hack constant.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  one clock; reset is synchronous and active-high.
REQ-007 data_in  in  W  unsigned fixed-point operand x.
REQ-008 valid_in  in  1  operand valid.
REQ-009 ready_in  out  1  engine can accept operand.
REQ-010 data_out  out  W  unsigned fixed-point result approx. 1/sqrt(x).
REQ-011 valid_out  out  1  result valid.
REQ-012 ready_out  in  1  downstream accepts result.
REQ-013 zero_err  out  1  result stems from zero operand; qualified by valid_out.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> TO_FLOAT -> HACK -> TO_FIX -> NR (NR_ITERS cycles, skipped when 0) -> DONE -> IDLE.
REQ-016 ready_in SHALL be combinational, high exactly when state is IDLE.
REQ-017 Operand accepted on edge where valid_in && ready_in; data_in captured into internal register that edge; later data_in changes SHALL have no effect.
REQ-018 TO_FLOAT: captured x converted to IEEE-754 single: sign 0, exponent = msb_index - FRACT_WIDTH + 127, mantissa = bits below msb left-aligned, truncated.
REQ-019 HACK: y0_bits = MAGIC - (float_bits >> 1), 32-bit unsigned wrap-around subtract.
REQ-020 TO_FIX: y0 converted to Q(INT_WIDTH.FRACT_WIDTH), truncate toward zero; values >= 2^INT_WIDTH saturate to all-ones; values below 1 LSB give 0.
REQ-021 NR: one iteration per cycle, y <= y*(1.5 - (x/2)*y*y); x/2 is captured x >> 1; intermediates 2W+2 bits; products rescaled by >> FRACT_WIDTH, truncated; negative bracket clamps to 0; result saturates to all-ones.
REQ-022 Iteration counter SHALL count 0..NR_ITERS-1 and clear on every entry to NR.
REQ-023 Latency: valid_out high in cycle following edge E0+3+NR_ITERS, where E0 is accept edge.
REQ-024 Zero operand: TO_FLOAT SHALL go directly to DONE, data_out = all-ones, zero_err = 1; latency 1 cycle.
REQ-025 DONE: valid_out = 1, data_out and zero_err held stable until edge with ready_out high; that edge returns FSM to IDLE and valid_out deasserts next cycle.
REQ-026 ready_out is ignored outside DONE; no result is ever dropped or duplicated.
REQ-027 Back-to-back throughput: one operand per 5+NR_ITERS cycles minimum (accept edge to next accept edge, ready_out held high).

Reset
REQ-028 rst high at an edge SHALL force state IDLE, valid_out 0, data_out 0, zero_err 0, busy 0, counter 0, all internal datapath registers 0, overriding any in-flight operation.
REQ-029 ready_in SHALL be 1 in the first cycle after reset deasserts; in-flight operand is discarded, no valid_out produced for it.

Structure
REQ-030 Package inv_sqrt_pkg SHALL hold state enum typedef, default MAGIC, and THREE_HALVES helper function parametrised on FRACT_WIDTH.
REQ-031 Sub-module inv_sqrt_nr_step (combinational, one Newton iteration, parameters INT_WIDTH/FRACT_WIDTH) SHALL be instantiated once and reused per iteration cycle.
REQ-032 Conversions SHALL be in-module combinational functions; no additional sub-modules.

Verification (defaults Q12.4, NR_ITERS=1 unless stated)
REQ-033 data_in=16'h0040 (4.0), ready_out=1 -> data_out=16'h0008 (0.5) +/-1 LSB, valid_out after 4 cycles, zero_err=0.
REQ-034 data_in=16'h0100 (16.0) then 16'h0010 (1.0) back-to-back -> 16'h0004 then 16'h0010 +/-1 LSB, accepts 6 cycles apart.
REQ-035 data_in=16'h0000 -> data_out=16'hFFFF, zero_err=1, valid_out one cycle after TO_FLOAT.
REQ-036 ready_out low 10 cycles in DONE -> valid_out, data_out stable, ready_in=0 throughout; result consumed on first ready_out-high edge.
REQ-037 rst pulsed one cycle while in NR -> next cycle IDLE, valid_out=0, data_out=0, ready_in=1; no stale result emitted.
REQ-038 NR_ITERS=0 and 3 builds, data_in=16'h0040 -> latency 3 and 6 cycles; error vs 0.5 non-increasing with NR_ITERS.
